// File: rtl/twiddle_rotator.sv
// Streaming twiddle rotation stage for a 16-point FFT: derives the twiddle exponent
// per sample, multiplies by W16^e with round-half-up and saturation, 3-cycle latency.
module twiddle_rotator #(
    parameter int DATA_WIDTH = 12,
    parameter int N          = 3,
    parameter int FRAC_BITS  = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic signed [DATA_WIDTH-1:0] in_re,
    input  logic signed [DATA_WIDTH-1:0] in_im,
    output logic        [N-1:0]          sel,
    input  logic signed [DATA_WIDTH-1:0] W_r,
    input  logic signed [DATA_WIDTH-1:0] W_i,
    output logic                         out_valid,
    output logic                         out_sof,
    output logic signed [DATA_WIDTH-1:0] out_re,
    output logic signed [DATA_WIDTH-1:0] out_im
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = PW + 1;

    localparam logic signed [SW-1:0]         RND   = SW'(2 ** (FRAC_BITS - 1));
    localparam logic signed [SW-1:0]         MAXV  = SW'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [SW-1:0]         MINV  = ~MAXV;
    localparam logic signed [DATA_WIDTH-1:0] MAX_O = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MIN_O = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    logic [3:0] cnt;
    logic [3:0] k;
    logic [1:0] g;
    logic [1:0] m;
    logic [1:0] b;
    logic [3:0] e;
    logic       neg;

    logic                         s1_valid;
    logic                         s1_sof;
    logic                         s1_neg;
    logic signed [DATA_WIDTH-1:0] s1_re;
    logic signed [DATA_WIDTH-1:0] s1_im;
    logic signed [DATA_WIDTH-1:0] s1_wr;
    logic signed [DATA_WIDTH-1:0] s1_wi;

    logic                 s2_valid;
    logic                 s2_sof;
    logic                 s2_neg;
    logic signed [PW-1:0] s2_rr;
    logic signed [PW-1:0] s2_ii;
    logic signed [PW-1:0] s2_ri;
    logic signed [PW-1:0] s2_ir;

    logic signed [SW-1:0]         p_re;
    logic signed [SW-1:0]         p_im;
    logic signed [DATA_WIDTH-1:0] q_re;
    logic signed [DATA_WIDTH-1:0] q_im;

    // Saturation happens before negation, so a clamped minimum flips to the maximum.
    function automatic logic signed [DATA_WIDTH-1:0] round_sat_neg(
        input logic signed [SW-1:0] p,
        input logic                 ng
    );
        logic signed [SW-1:0]         r;
        logic signed [DATA_WIDTH-1:0] s;
        r = (p + RND) >>> FRAC_BITS;
        if (r > MAXV) begin
            s = MAX_O;
        end else if (r < MINV) begin
            s = MIN_O;
        end else begin
            s = r[DATA_WIDTH-1:0];
        end
        if (ng) begin
            s = (s == MIN_O) ? MAX_O : -s;
        end
        return s;
    endfunction

    // Exponent e = m * bitrev(g); W16^8 = -1 lets entries 0..7 cover e up to 9.
    always_comb begin
        k   = (in_valid && in_sof) ? 4'd0 : cnt;
        g   = k[3:2];
        m   = k[1:0];
        b   = {g[0], g[1]};
        e   = {2'b00, m} * {2'b00, b};
        sel = e[N-1:0];
        neg = e[3];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (in_valid) begin
            cnt <= k + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_neg   <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_wr    <= '0;
            s1_wi    <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sof <= in_sof;
                s1_neg <= neg;
                s1_re  <= in_re;
                s1_im  <= in_im;
                s1_wr  <= W_r;
                s1_wi  <= W_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_neg   <= 1'b0;
            s2_rr    <= '0;
            s2_ii    <= '0;
            s2_ri    <= '0;
            s2_ir    <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sof <= s1_sof;
                s2_neg <= s1_neg;
                s2_rr  <= PW'(s1_re) * PW'(s1_wr);
                s2_ii  <= PW'(s1_im) * PW'(s1_wi);
                s2_ri  <= PW'(s1_re) * PW'(s1_wi);
                s2_ir  <= PW'(s1_im) * PW'(s1_wr);
            end
        end
    end

    always_comb begin
        p_re = SW'(s2_rr) - SW'(s2_ii);
        p_im = SW'(s2_ri) + SW'(s2_ir);
        q_re = round_sat_neg(p_re, s2_neg);
        q_im = round_sat_neg(p_im, s2_neg);
    end

    // Output data holds across bubbles; only valid/sof drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            out_valid <= s2_valid;
            out_sof   <= s2_valid & s2_sof;
            if (s2_valid) begin
                out_re <= q_re;
                out_im <= q_im;
            end
        end
    end

endmodule

// File: tb/tb_twiddle_rotator.sv
// Randomized self-checking bench for twiddle_rotator with a behavioural model
// of the FFT twiddle rotation and a model of the external twiddle lookup.
module tb_twiddle_rotator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [11:0] in_re = '0;
    logic [11:0] in_im = '0;
    logic [2:0]  sel;
    logic [11:0] W_r;
    logic [11:0] W_i;
    logic        out_valid;
    logic        out_sof;
    logic [11:0] out_re;
    logic [11:0] out_im;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    twiddle_rotator #(.DATA_WIDTH(12), .N(3), .FRAC_BITS(10)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_im(in_im), .sel(sel), .W_r(W_r), .W_i(W_i),
        .out_valid(out_valid), .out_sof(out_sof), .out_re(out_re), .out_im(out_im)
    );

    // W16^i = exp(-j*2*pi*i/16) in Q1.10
    function automatic int twr(int i);
        case (i & 7)
            0: return 1024;  1: return 946;   2: return 724;   3: return 392;
            4: return 0;     5: return -392;  6: return -724;  default: return -946;
        endcase
    endfunction

    function automatic int twi(int i);
        case (i & 7)
            0: return 0;      1: return -392;  2: return -724;  3: return -946;
            4: return -1024;  5: return -946;  6: return -724;  default: return -392;
        endcase
    endfunction

    assign W_r = 12'(twr(int'(sel)));
    assign W_i = 12'(twi(int'(sel)));

    function automatic int expo(int k);
        int g;
        g = k / 4;
        return (k % 4) * (((g & 1) << 1) | ((g >> 1) & 1));
    endfunction

    // One rotated component, returned as a 12-bit pattern.
    function automatic int rot(int re, int im, int e, bit imag);
        int wr, wi, p, r;
        wr = twr(e % 8);
        wi = twi(e % 8);
        p  = imag ? (re * wi + im * wr) : (re * wr - im * wi);
        r  = (p + 512) >>> 10;
        if (r > 2047) r = 2047;
        if (r < -2048) r = -2048;
        if (e >= 8) r = (r == -2048) ? 2047 : -r;
        return r & 12'hFFF;
    endfunction

    typedef struct {
        bit v;
        bit sof;
        int re;
        int im;
    } ent_t;

    int   mcnt;
    ent_t d0, d1;
    bit   exp_valid, exp_sof;
    int   exp_re, exp_im;

    // Behavioural model: results computed at entry, delivered three edges later.
    always @(posedge clk or negedge rst_n) begin
        int   k;
        int   e;
        ent_t nw;
        if (!rst_n) begin
            mcnt = 0;
            d0 = '{0, 0, 0, 0};
            d1 = '{0, 0, 0, 0};
            exp_valid = 0; exp_sof = 0; exp_re = 0; exp_im = 0;
        end else begin
            exp_valid = d1.v;
            exp_sof   = d1.v && d1.sof;
            if (d1.v) begin
                exp_re = d1.re;
                exp_im = d1.im;
            end
            d1 = d0;
            k = (in_valid && in_sof) ? 0 : mcnt;
            e = expo(k);
            nw.v   = in_valid;
            nw.sof = in_sof;
            nw.re  = rot(int'($signed(in_re)), int'($signed(in_im)), e, 1'b0);
            nw.im  = rot(int'($signed(in_re)), int'($signed(in_im)), e, 1'b1);
            d0 = nw;
            if (in_valid) mcnt = (k + 1) % 16;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    int obs_re[$];
    int obs_im[$];
    int obs_sof[$];

    always @(posedge clk) begin
        #1;
        checkOutput("out_valid", int'(out_valid), int'(exp_valid));
        checkOutput("out_sof", int'(out_sof), int'(exp_sof));
        checkOutput("out_re", int'(out_re), exp_re);
        checkOutput("out_im", int'(out_im), exp_im);
        checkOutput("sel", int'(sel), expo((in_valid && in_sof) ? 0 : mcnt) % 8);
        if (out_valid) begin
            obs_re.push_back(int'(out_re));
            obs_im.push_back(int'(out_im));
            obs_sof.push_back(int'(out_sof));
        end
    end

    int last_sel;

    task automatic applyStimulus(input bit v, input bit sof, input logic [11:0] re, input logic [11:0] im);
        @(negedge clk);
        in_valid = v;
        in_sof   = sof;
        in_re    = re;
        in_im    = im;
        #1;
        last_sel = int'(sel);
    endtask

    function automatic logic [11:0] rnd12();
        case ($urandom_range(0, 7))
            0: return 12'h7FF;
            1: return 12'h800;
            default: return 12'($urandom);
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, rnd12(), rnd12());
    endtask

    logic [11:0] fre[16];
    logic [11:0] fim[16];
    int          fgap[16];
    int          fsel[16];
    int          ref_re[16];
    int          ref_im[16];
    int          sel_seq[16] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 1};

    task automatic playFrame();
        obs_re.delete(); obs_im.delete(); obs_sof.delete();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, i == 0, fre[i], fim[i]);
            fsel[i] = last_sel;
            idle(fgap[i]);
        end
        idle(5);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int lat;
        int sof_rest;

        checkOutput("model_k0_re", rot(256, 0, 0, 0), 'h100);
        checkOutput("model_k5_re", rot(256, 0, 2, 0), 'h0B5);
        checkOutput("model_k5_im", rot(256, 0, 2, 1), 'hF4B);
        checkOutput("model_k15_re", rot(256, 0, 9, 0), 'hF13);
        checkOutput("model_k15_im", rot(256, 0, 9, 1), 'h062);
        checkOutput("model_min_re", rot(-2048, 0, 9, 0), 'h764);
        checkOutput("model_min_im", rot(-2048, 0, 9, 1), 'hCF0);

        // reset with random inputs
        for (int i = 0; i < 6; i++)
            applyStimulus(1'($urandom), 1'($urandom), rnd12(), rnd12());
        checkOutput("reset_cnt", int'(dut.cnt), 0);
        checkOutput("reset_sel", last_sel, 0);
        @(negedge clk);
        in_valid = 0; in_sof = 0; rst_n = 1;
        idle(2);

        // first-sample latency
        applyStimulus(1'b1, 1'b1, 12'h123, 12'h045);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && lat == 0) lat = i;
            if (i == 1) begin
                @(negedge clk);
                in_valid = 0; in_sof = 0;
            end
        end
        checkOutput("latency", lat, 3);

        // unit-amplitude frame
        for (int i = 0; i < 16; i++) begin fre[i] = 12'h100; fim[i] = 12'h000; fgap[i] = 0; end
        playFrame();
        for (int i = 0; i < 16; i++) checkOutput($sformatf("sel_k%0d", i), fsel[i], sel_seq[i]);
        checkOutput("frame_count", obs_re.size(), 16);
        checkOutput("k0_re", obs_re[0], 'h100);
        checkOutput("k0_im", obs_im[0], 'h000);
        checkOutput("k5_re", obs_re[5], 'h0B5);
        checkOutput("k5_im", obs_im[5], 'hF4B);
        checkOutput("k15_re", obs_re[15], 'hF13);
        checkOutput("k15_im", obs_im[15], 'h062);
        checkOutput("sof_k0", obs_sof[0], 1);
        sof_rest = 0;
        for (int i = 1; i < obs_sof.size(); i++) sof_rest += obs_sof[i];
        checkOutput("sof_rest", sof_rest, 0);

        // saturation corners
        for (int i = 0; i < 16; i++) begin fre[i] = rnd12(); fim[i] = rnd12(); end
        fre[5] = 12'h7FF; fim[5] = 12'h7FF;
        fre[15] = 12'h800; fim[15] = 12'h800;
        playFrame();
        checkOutput("sat_k5_re", obs_re[5], 'h7FF);
        checkOutput("sat_k5_im", obs_im[5], 'h000);
        checkOutput("sat_k15_re", obs_re[15], 'h7FF);
        checkOutput("sat_k15_im", obs_im[15], 'h454);

        // bubbles must not change results
        for (int i = 0; i < 16; i++) begin fre[i] = rnd12(); fim[i] = rnd12(); end
        playFrame();
        for (int i = 0; i < 16; i++) begin ref_re[i] = obs_re[i]; ref_im[i] = obs_im[i]; end
        fgap[3] = 1; fgap[9] = 3;
        playFrame();
        checkOutput("gap_count", obs_re.size(), 16);
        for (int i = 0; i < 16 && i < obs_re.size(); i++) begin
            checkOutput($sformatf("gap_re_%0d", i), obs_re[i], ref_re[i]);
            checkOutput($sformatf("gap_im_%0d", i), obs_im[i], ref_im[i]);
        end
        fgap[3] = 0; fgap[9] = 0;

        // mid-frame resync
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, i == 0, rnd12(), rnd12());
        applyStimulus(1'b1, 1'b1, rnd12(), rnd12());
        checkOutput("resync_sel", last_sel, 0);
        @(posedge clk);
        #1;
        checkOutput("resync_cnt", int'(dut.cnt), 1);
        for (int i = 1; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, rnd12(), rnd12());
            checkOutput($sformatf("resync_sel_k%0d", i), last_sel, sel_seq[i]);
        end
        idle(5);

        // reset with two results in flight
        applyStimulus(1'b1, 1'b1, rnd12(), rnd12());
        applyStimulus(1'b1, 1'b0, rnd12(), rnd12());
        @(negedge clk);
        in_valid = 0; in_sof = 0; rst_n = 0;
        idle(2);
        obs_re.delete(); obs_im.delete(); obs_sof.delete();
        @(negedge clk);
        rst_n = 1;
        idle(6);
        checkOutput("flush_outputs", obs_re.size(), 0);
        checkOutput("flush_cnt", int'(dut.cnt), 0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, rnd12(), rnd12());
        checkOutput("after_reset_k5_sel", last_sel, 2);
        idle(5);

        // random traffic
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rnd12(), rnd12());
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
